// File: rtl/jtag_sample_link.sv
// rtl/jtag_sample_link.sv - Avalon-MM master on the JTAG UART data register
// Decodes chunked DAC setpoint frames; uploads ADC channel results as chunked bytes.
module jtag_sample_link #(
  parameter int DAC_W    = 12,
  parameter int ADC_W    = 10,
  parameter int NUM_CH   = 24,
  parameter int POLL_DIV = 50
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    av_chipselect,
  output logic                    av_address,
  output logic                    av_read,
  output logic                    av_write,
  output logic [31:0]             av_writedata,
  input  logic [31:0]             av_readdata,
  input  logic                    av_waitrequest,
  input  logic [NUM_CH*ADC_W-1:0] adc_values,
  output logic [DAC_W-1:0]        dac_value,
  output logic                    dac_push,
  output logic                    frame_err,
  output logic                    busy
);
  localparam int DAC_CHUNKS = (DAC_W + 5) / 6;
  localparam int ADC_CHUNKS = (ADC_W + 4) / 5;
  localparam int AW = DAC_CHUNKS * 6;
  localparam int SW = ADC_CHUNKS * 5;
  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int KW = (DAC_CHUNKS > 1) ? $clog2(DAC_CHUNKS) : 1;
  localparam int JW = (ADC_CHUNKS > 1) ? $clog2(ADC_CHUNKS) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(DAC_CHUNKS - 1);
  localparam logic [JW-1:0] J_LAST    = JW'(ADC_CHUNKS - 1);
  localparam logic [5:0]    NUM_CH6   = 6'(NUM_CH);
  localparam logic [5:0]    CH_LAST   = 6'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, DECODE, LOAD, WR_REQ} state_t;
  state_t state, state_n;

  logic [PW-1:0] poll_cnt;
  logic [KW-1:0] k;
  logic [JW-1:0] j;
  logic [5:0]    ch;
  logic          dump_all, discard, gap, rx_valid;
  logic [7:0]    rx_byte;
  logic [AW-1:0] asm_buf, asm_next;
  logic [SW-1:0] snap, snap_in;

  logic [5:0] payload;
  logic       is_last, is_cmd, cmd_valid, cmd_ok, k_final, j_final, more_ch;
  logic [4:0] chunk;
  logic       unused_bits;

  assign payload   = rx_byte[5:0];
  assign is_last   = rx_byte[7];
  assign is_cmd    = rx_byte[6];
  assign cmd_valid = (payload < NUM_CH6) || (payload == 6'd63);
  assign cmd_ok    = rx_valid && !discard && is_cmd && is_last && cmd_valid;
  assign k_final   = (k == K_LAST);
  assign j_final   = (j == J_LAST);
  assign more_ch   = dump_all && (ch != CH_LAST);
  assign chunk     = snap[int'(j)*5 +: 5];

  assign av_chipselect = 1'b1;
  assign av_address    = 1'b0;
  assign unused_bits   = ^{av_readdata[31:16], av_readdata[14:8]};

  always_comb begin
    asm_next = asm_buf;
    asm_next[int'(k)*6 +: 6] = payload;
  end

  always_comb begin
    snap_in = '0;
    snap_in[ADC_W-1:0] = adc_values[int'(ch)*ADC_W +: ADC_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n      = state;
    av_read      = 1'b0;
    av_write     = 1'b0;
    busy         = 1'b0;
    av_writedata = '0;
    case (state)
      IDLE:   if (poll_cnt == POLL_LAST) state_n = RD_REQ;
      RD_REQ: begin
        av_read = 1'b1;
        if (!av_waitrequest) state_n = DECODE;
      end
      DECODE: state_n = cmd_ok ? LOAD : IDLE;
      LOAD: begin
        busy    = 1'b1;
        state_n = WR_REQ;
      end
      WR_REQ: begin
        busy         = 1'b1;
        av_write     = !gap;
        av_writedata = {24'b0, (j_final ? 3'b111 : 3'b000), chunk};
        if (gap && j_final) state_n = more_ch ? LOAD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt  <= '0;
      k         <= '0;
      j         <= '0;
      ch        <= '0;
      dump_all  <= 1'b0;
      discard   <= 1'b0;
      gap       <= 1'b0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      asm_buf   <= '0;
      snap      <= '0;
      dac_value <= '0;
      dac_push  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dac_push  <= 1'b0;
      frame_err <= 1'b0;
      poll_cnt  <= '0;
      case (state)
        IDLE: poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + PW'(1);
        RD_REQ: if (!av_waitrequest) begin
          rx_valid <= av_readdata[15];
          rx_byte  <= av_readdata[7:0];
        end
        DECODE: if (rx_valid) begin
          if (discard) begin
            // Drop everything up to and including the next frame terminator
            if (is_last) begin
              discard <= 1'b0;
              k       <= '0;
            end
          end else if (!is_cmd) begin
            if (k_final) begin
              k <= '0;
              if (is_last) begin
                dac_value <= asm_next[DAC_W-1:0];
                dac_push  <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                discard   <= 1'b1;
              end
            end else if (is_last) begin
              frame_err <= 1'b1;
              k         <= '0;
            end else begin
              asm_buf <= asm_next;
              k       <= k + KW'(1);
            end
          end else begin
            k <= '0;
            if (k != '0 || !is_last || !cmd_valid) frame_err <= 1'b1;
            if (cmd_ok) begin
              ch       <= (payload == 6'd63) ? 6'd0 : payload;
              dump_all <= (payload == 6'd63);
            end
          end
        end
        LOAD: begin
          snap <= snap_in;
          j    <= '0;
          gap  <= 1'b0;
        end
        WR_REQ: begin
          if (!gap) begin
            if (!av_waitrequest) gap <= 1'b1;
          end else begin
            gap <= 1'b0;
            if (!j_final)     j  <= j + JW'(1);
            else if (more_ch) ch <= ch + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_sample_link.sv
// tb/tb_jtag_sample_link.sv - directed vector bench for jtag_sample_link
// Avalon slave model feeds rx bytes and logs accepted writes.
module tb_jtag_sample_link;
  localparam int DAC_W = 12, ADC_W = 10, NUM_CH = 24, POLL_DIV = 50;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    av_chipselect, av_address, av_read, av_write;
  logic [31:0]             av_writedata;
  logic [31:0]             av_readdata = '0;
  logic                    av_waitrequest = 1'b0;
  logic [NUM_CH*ADC_W-1:0] adc_values = '0;
  logic [DAC_W-1:0]        dac_value;
  logic                    dac_push, frame_err, busy;

  jtag_sample_link #(.DAC_W(DAC_W), .ADC_W(ADC_W), .NUM_CH(NUM_CH), .POLL_DIV(POLL_DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .av_chipselect(av_chipselect), .av_address(av_address),
    .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .adc_values(adc_values), .dac_value(dac_value), .dac_push(dac_push),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] wlog[$];
  int read_times[$];
  int cyc = 0, nreads = 0, stall_left = 0;
  int push_hi = 0, err_hi = 0, wr_hi = 0, wd_unstable = 0, viol = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  logic [31:0] prev_wd = '0;

  always @(negedge clk) begin
    cyc++;
    if (av_write && stall_left > 0) begin
      av_waitrequest = 1'b1;
      stall_left--;
    end else begin
      av_waitrequest = 1'b0;
    end
    if (av_write) begin
      wr_hi++;
      if (prev_wr && av_writedata != prev_wd) wd_unstable++;
      if (!busy) viol++;
      if (!av_waitrequest) wlog.push_back(av_writedata[7:0]);
    end
    if (av_writedata[31:8] != 24'd0) viol++;
    if (av_read && (av_write || busy)) viol++;
    if (av_read && !prev_rd) read_times.push_back(cyc);
    prev_wr = av_write;
    prev_wd = av_writedata;
    prev_rd = av_read;
    if (av_read && !av_waitrequest) begin
      nreads++;
      if (rxq.size() != 0) av_readdata = {16'h0000, 8'h80, rxq.pop_front()};
      else                 av_readdata = '0;
    end
    if (dac_push)  push_hi++;
    if (frame_err) err_hi++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear();
    wlog.delete();
    read_times.delete();
    push_hi = 0; err_hi = 0; wr_hi = 0; wd_unstable = 0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (rxq.size() != 0 && n < 4000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    while (busy && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) check("settle_timeout", n, 0);
    repeat (POLL_DIV + 10) @(negedge clk);
  endtask

  typedef struct {
    int              n;
    logic [5:0][7:0] b;
    logic [11:0]     val;
    int              push;
    int              err;
    int              nw;
  } vec_t;

  function automatic vec_t mk(int n, logic [47:0] bs, logic [11:0] v, int p, int e, int w);
    vec_t r;
    r.n = n; r.b = bs; r.val = v; r.push = p; r.err = e; r.nw = w;
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(int idx);
    logic [9:0] v;
    v = adc_values[(idx/2)*ADC_W +: ADC_W];
    return (idx % 2 == 0) ? {3'b000, v[4:0]} : {3'b111, v[9:5]};
  endfunction

  vec_t vecs[9];

  initial begin
    int n, bad, r0;
    vecs[0] = mk(2, 48'h8A15,         12'h295, 1, 0, 0);
    vecs[1] = mk(2, 48'hBF3F,         12'hFFF, 1, 0, 0);
    vecs[2] = mk(2, 48'h8000,         12'h000, 1, 0, 0);
    vecs[3] = mk(3, 48'h912281,       12'h462, 1, 1, 0);
    vecs[4] = mk(6, 48'h860584030201, 12'h185, 1, 1, 0);
    vecs[5] = mk(1, 48'h41,           12'h185, 0, 1, 0);
    vecs[6] = mk(1, 48'hE0,           12'h185, 0, 1, 0);
    vecs[7] = mk(2, 48'hC02A,         12'h185, 0, 1, 2);
    vecs[8] = mk(2, 48'h4007,         12'h185, 0, 1, 0);
    for (int i = 0; i < NUM_CH; i++) adc_values[i*ADC_W +: ADC_W] = 10'(i * 37 + 5);
    adc_values[3*ADC_W +: ADC_W] = 10'h2B7;

    repeat (3) @(negedge clk);
    check("rst_av_read", av_read, 0);
    check("rst_av_write", av_write, 0);
    check("rst_writedata", av_writedata, 0);
    check("rst_dac_value", dac_value, 0);
    check("rst_push_err_busy", {dac_push, frame_err, busy}, 0);
    check("chipselect_address", {av_chipselect, av_address}, 2'b10);
    reset_n = 1'b1;

    clear();
    repeat (3 * (POLL_DIV + 2) + 10) @(negedge clk);
    check("idle_reads_seen", read_times.size() >= 3, 1);
    if (read_times.size() >= 3)
      check("poll_spacing", read_times[2] - read_times[1], POLL_DIV + 2);
    check("idle_no_push", push_hi, 0);

    for (int v = 0; v < 9; v++) begin
      clear();
      for (int i = 0; i < vecs[v].n; i++) rxq.push_back(vecs[v].b[i]);
      settle();
      check($sformatf("vec%0d_dac_value", v), dac_value, vecs[v].val);
      check($sformatf("vec%0d_push_cycles", v), push_hi, vecs[v].push);
      check($sformatf("vec%0d_err_cycles", v), err_hi, vecs[v].err);
      check($sformatf("vec%0d_writes", v), wlog.size(), vecs[v].nw);
    end

    clear();
    rxq.push_back(8'hC3);
    settle();
    check("up_count", wlog.size(), 2);
    if (wlog.size() == 2) check("up_bytes", {wlog[0], wlog[1]}, 16'h17F5);
    check("up_write_cycles", wr_hi, 2);
    r0 = nreads;
    repeat (POLL_DIV + 5) @(negedge clk);
    check("up_poll_resumes", nreads > r0, 1);

    clear();
    stall_left = 3;
    rxq.push_back(8'hC3);
    settle();
    check("stall_write_cycles", wr_hi, 5);
    check("stall_data_stable", wd_unstable, 0);
    check("stall_count", wlog.size(), 2);
    if (wlog.size() == 2) check("stall_bytes", {wlog[0], wlog[1]}, 16'h17F5);

    clear();
    rxq.push_back(8'hFF);
    settle();
    check("dump_count", wlog.size(), 2 * NUM_CH);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] != exp_byte(i)) bad++;
    check("dump_order", bad, 0);

    clear();
    rxq.push_back(8'hFF);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(av_write && wlog.size() == 10) && n < 4000);
    check("dump_reached_byte10", n < 4000, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_av_write", av_write, 0);
    check("mid_rst_av_read", av_read, 0);
    check("mid_rst_outputs", {av_writedata, dac_value, dac_push, frame_err, busy}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!av_read && !av_write && n < 200) begin @(negedge clk); n++; end
    check("post_rst_first_is_read", {av_read, av_write}, 2'b10);
    check("post_rst_no_more_writes", wlog.size(), 10);

    check("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
